// File: rtl/decode_pkg.sv
// decode_pkg: decode bundle type, ALU/immediate/opcode constants and small decode helpers.
package decode_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASS_B = 5'd15;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  typedef struct packed {
    logic       reg_write;
    logic       load;
    logic       store;
    logic       branch;
    logic       jump;
    logic [1:0] mem_to_reg;
    logic       operand_a;
    logic       operand_b;
    logic [2:0] imm_sel;
    logic [4:0] alu_control;
    logic [2:0] fun3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_t;
  // alt selects SUB over ADD and SRA over SRL
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  // {reads rs2, reads rs1} for an opcode
  function automatic logic [1:0] rs_use(input logic [6:0] op);
    return {op == OP_R || op == OP_STORE || op == OP_BRANCH,
            op == OP_R || op == OP_I || op == OP_LOAD || op == OP_STORE || op == OP_BRANCH || op == OP_JALR};
  endfunction
endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I(+M) instruction decode into ctrl_t and immediate.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o
);
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        bad;
  logic [31:0] imm32;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  always_comb begin
    ctrl_o      = '0;
    ctrl_o.fun3 = f3;
    ctrl_o.rd   = instr_i[11:7];
    ctrl_o.rs1  = instr_i[19:15];
    ctrl_o.rs2  = instr_i[24:20];
    bad         = 1'b0;
    case (op)
      OP_R: begin
        ctrl_o.reg_write   = 1'b1;
        bad                = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && EN_M));
        ctrl_o.alu_control = bad ? ALU_ADD : f7 == 7'h01 ? ALU_MUL + 5'(f3) : alu_base(f3, f7 == 7'h20);
      end
      OP_I: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.operand_b   = 1'b1;
        bad                = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        ctrl_o.alu_control = bad ? ALU_ADD : alu_base(f3, f3 == 3'd5 && f7 == 7'h20);
      end
      OP_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.load       = 1'b1;
        ctrl_o.mem_to_reg = WB_MEM;
        ctrl_o.operand_b  = 1'b1;
        bad               = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        ctrl_o.store     = 1'b1;
        ctrl_o.operand_b = 1'b1;
        ctrl_o.imm_sel   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_o.branch      = 1'b1;
        ctrl_o.imm_sel     = IMM_B;
        ctrl_o.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.mem_to_reg = WB_PC4;
        ctrl_o.operand_a  = 1'b1;
        ctrl_o.operand_b  = 1'b1;
        ctrl_o.imm_sel    = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.mem_to_reg = WB_PC4;
        ctrl_o.operand_b  = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.operand_b   = 1'b1;
        ctrl_o.imm_sel     = IMM_U;
        ctrl_o.alu_control = ALU_PASS_B;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.operand_a = 1'b1;
        ctrl_o.operand_b = 1'b1;
        ctrl_o.imm_sel   = IMM_U;
      end
      default: bad = 1'b1;
    endcase
    ctrl_o.illegal = bad;
    if (bad) {ctrl_o.reg_write, ctrl_o.load, ctrl_o.store, ctrl_o.branch, ctrl_o.jump} = '0;
    imm32 = ctrl_o.imm_sel == IMM_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
            ctrl_o.imm_sel == IMM_B ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
            ctrl_o.imm_sel == IMM_J ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
            ctrl_o.imm_sel == IMM_U ? {instr_i[31:12], 12'h000} :
                                      {{20{instr_i[31]}}, instr_i[31:20]};
    imm_o = XLEN'($signed(imm32));
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with valid/ready handshake, load-use bubble insertion,
// flush and a saturating bubble counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output ctrl_t            out_ctrl,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] stall_cnt
);
  ctrl_t             dec_ctrl, ctrl_q, ctrl_d;
  logic [XLEN-1:0]   dec_imm, imm_q, imm_d, pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        use_rs;
  logic              hazard, accept;
  decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_dec (
    .instr_i(in_instr),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm)
  );
  assign use_rs = rs_use(in_instr[6:0]);
  // held load whose destination the offered instruction reads; x0 never blocks
  assign hazard = valid_q && ctrl_q.load && ctrl_q.rd != 5'd0 && in_valid &&
                  ((use_rs[0] && in_instr[19:15] == ctrl_q.rd) || (use_rs[1] && in_instr[24:20] == ctrl_q.rd));
  assign in_ready = !rst && (flush || ((!valid_q || out_ready) && !hazard));
  assign accept   = in_valid && in_ready && !flush;
  always_comb begin
    valid_d = !flush && (accept || (valid_q && !out_ready));
    ctrl_d  = accept ? dec_ctrl : ctrl_q;
    imm_d   = accept ? dec_imm : imm_q;
    pc_d    = accept ? in_pc : pc_q;
    cnt_d   = (hazard && out_ready && !flush && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_imm   = imm_q;
  assign out_pc    = pc_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage (EN_M=0 and EN_M=1 with a
// 3-bit counter) against an instruction-level reference model.
module tb_decode_stage;
  import decode_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, in_ready_m, out_valid, out_valid_m;
  ctrl_t       out_ctrl, out_ctrl_m;
  logic [31:0] out_imm, out_imm_m, out_pc, out_pc_m, stall_cnt;
  logic [2:0]  stall_cnt_m;
  int          n_chk = 0, n_fail = 0;
  bit          started = 1'b0;
  bit          m_v = 1'b0, m_zero = 1'b1;
  logic [31:0] m_instr = '0, m_pc = '0;
  int          m_cnt = 0;

  decode_stage #(.XLEN(32), .EN_M(1'b0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_imm(out_imm),
    .out_pc(out_pc), .stall_cnt(stall_cnt));
  decode_stage #(.XLEN(32), .EN_M(1'b1), .CNT_W(3)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid_m), .out_ready(out_ready), .out_ctrl(out_ctrl_m), .out_imm(out_imm_m),
    .out_pc(out_pc_m), .stall_cnt(stall_cnt_m));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic ctrl_t ref_dec(input logic [31:0] w, input bit m);
    ctrl_t      c = '0;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic [4:0] alu_tab [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    bit         bad = 1'b0;
    c.fun3 = f3; c.rd = w[11:7]; c.rs1 = w[19:15]; c.rs2 = w[24:20];
    if (op == 7'h33) begin
      c.reg_write = 1'b1;
      if (f7 == 7'h00) c.alu_control = alu_tab[f3];
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) c.alu_control = alu_tab[f3] + 5'd1;
      else if (f7 == 7'h01 && m) c.alu_control = 5'd16 + 5'(f3);
      else bad = 1'b1;
    end else if (op == 7'h13) begin
      c.reg_write = 1'b1; c.operand_b = 1'b1;
      if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) bad = 1'b1;
      else c.alu_control = alu_tab[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 5'd1 : 5'd0);
    end else if (op == 7'h03) begin
      c.reg_write = 1'b1; c.load = 1'b1; c.mem_to_reg = 2'd1; c.operand_b = 1'b1;
      bad = f3 == 3'd3 || f3 >= 3'd6;
    end else if (op == 7'h23) begin
      c.store = 1'b1; c.operand_b = 1'b1; c.imm_sel = 3'd1;
    end else if (op == 7'h63) begin
      c.branch = 1'b1; c.imm_sel = 3'd2; c.alu_control = 5'd1;
    end else if (op == 7'h6f) begin
      c.reg_write = 1'b1; c.jump = 1'b1; c.mem_to_reg = 2'd2; c.operand_a = 1'b1; c.operand_b = 1'b1; c.imm_sel = 3'd3;
    end else if (op == 7'h67) begin
      c.reg_write = 1'b1; c.jump = 1'b1; c.mem_to_reg = 2'd2; c.operand_b = 1'b1;
    end else if (op == 7'h37) begin
      c.reg_write = 1'b1; c.operand_b = 1'b1; c.imm_sel = 3'd4; c.alu_control = 5'd15;
    end else if (op == 7'h17) begin
      c.reg_write = 1'b1; c.operand_a = 1'b1; c.operand_b = 1'b1; c.imm_sel = 3'd4;
    end else bad = 1'b1;
    if (bad) begin
      c.illegal = 1'b1; c.reg_write = 1'b0; c.load = 1'b0; c.store = 1'b0; c.branch = 1'b0; c.jump = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [6:0] op = w[6:0];
    if (op == 7'h23) return 32'($signed({w[31:25], w[11:7]}));
    if (op == 7'h63) return 32'($signed({w[31], w[7], w[30:25], w[11:8]})) << 1;
    if (op == 7'h6f) return 32'($signed({w[31], w[19:12], w[20], w[30:21]})) << 1;
    if (op inside {7'h37, 7'h17}) return {w[31:12], 12'h000};
    return 32'($signed(w[31:20]));
  endfunction

  function automatic bit reads(input logic [31:0] w, input logic [4:0] r);
    logic [6:0] op = w[6:0];
    return (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67} && w[19:15] == r) ||
           (op inside {7'h33, 7'h23, 7'h63} && w[24:20] == r);
  endfunction

  function automatic bit model_hz();
    ctrl_t h = ref_dec(m_instr, 1'b0);
    return m_v && h.load && h.rd != 5'd0 && in_valid && reads(in_instr, h.rd);
  endfunction

  function automatic bit exp_ready();
    return !rst && (flush || ((!m_v || out_ready) && !model_hz()));
  endfunction

  // Instruction-level model of what the stage holds.
  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_v <= 1'b0; m_zero <= 1'b1; m_cnt <= 0;
    end else if (flush) m_v <= 1'b0;
    else if (model_hz() && out_ready) begin
      m_v <= 1'b0; m_cnt <= m_cnt + 1;
    end else if (in_valid && exp_ready()) begin
      m_v <= 1'b1; m_zero <= 1'b0; m_instr <= in_instr; m_pc <= in_pc;
    end else if (out_ready) m_v <= 1'b0;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("in_ready_m", 64'(in_ready_m), 64'(exp_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_v));
      chk("out_valid_m", 64'(out_valid_m), 64'(m_v));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("stall_cnt_m", 64'(stall_cnt_m), 64'(m_cnt > 7 ? 7 : m_cnt));
      if (m_v || m_zero) begin
        chk("ctrl", 64'(out_ctrl), m_zero ? 64'(0) : 64'(ref_dec(m_instr, 1'b0)));
        chk("ctrl_m", 64'(out_ctrl_m), m_zero ? 64'(0) : 64'(ref_dec(m_instr, 1'b1)));
        chk("imm", 64'(out_imm), m_zero ? 64'(0) : 64'(ref_imm(m_instr)));
        chk("imm_m", 64'(out_imm_m), m_zero ? 64'(0) : 64'(ref_imm(m_instr)));
        chk("pc", 64'(out_pc), m_zero ? 64'(0) : 64'(m_pc));
        chk("pc_m", 64'(out_pc_m), m_zero ? 64'(0) : 64'(m_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction until accepted; lows counts cycles spent with in_ready low.
  task automatic send(input logic [31:0] w, input logic [31:0] pc, output int lows);
    in_valid = 1'b1; in_instr = w; in_pc = pc; lows = 0;
    #1;
    while (!in_ready && lows < 8) begin
      lows++;
      tick();
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: instr %h not accepted within 8 cycles", w);
    end
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    logic [6:0] op = ops[$urandom_range(0, 9)];
    logic [6:0] f7 = f7s[$urandom_range(0, 3)];
    if ($urandom_range(0, 19) == 0) op = 7'($urandom);
    if ($urandom_range(0, 4) == 0) f7 = 7'($urandom);
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_ctrl", 64'(out_ctrl), 64'(0));
    chk("rst_cnt", 64'(stall_cnt), 64'(0));
    rst = 1'b0; out_ready = 1'b1;
    send(32'h002081B3, 32'h100, lows);
    chk("add_lows", 64'(lows), 64'(0));
    chk("add_valid", 64'(out_valid), 64'(1));
    chk("add_alu", 64'(out_ctrl.alu_control), 64'(0));
    chk("add_rw", 64'(out_ctrl.reg_write), 64'(1));
    chk("add_rd", 64'(out_ctrl.rd), 64'(3));
    send(32'h402081B3, 32'h104, lows);
    chk("sub_alu", 64'(out_ctrl.alu_control), 64'(1));
    send(32'h022081B3, 32'h108, lows);
    chk("mul_illegal", 64'(out_ctrl.illegal), 64'(1));
    chk("mul_rw", 64'(out_ctrl.reg_write), 64'(0));
    chk("mul_alu_m", 64'(out_ctrl_m.alu_control), 64'(16));
    chk("mul_legal_m", 64'(out_ctrl_m.illegal), 64'(0));
    send(32'h0000A283, 32'h200, lows);
    send(32'h00528333, 32'h204, lows);
    chk("lu_lows", 64'(lows), 64'(1));
    chk("lu_cnt", 64'(stall_cnt), 64'(1));
    chk("lu_pc", 64'(out_pc), 64'(32'h204));
    send(32'h00002003, 32'h208, lows);
    send(32'h00000333, 32'h20C, lows);
    chk("x0_lows", 64'(lows), 64'(0));
    chk("x0_cnt", 64'(stall_cnt), 64'(1));
    tick();
    out_ready = 1'b0;
    send(32'h00500093, 32'h300, lows);
    in_valid = 1'b1; in_instr = 32'h00100113; in_pc = 32'h304;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 64'(in_ready), 64'(0));
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_pc", 64'(out_pc), 64'(32'h300));
      chk("bp_imm", 64'(out_imm), 64'(5));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_next_pc", 64'(out_pc), 64'(32'h304));
    chk("bp_next_imm", 64'(out_imm), 64'(1));
    tick();
    chk("bp_drained", 64'(out_valid), 64'(0));
    send(32'h0000A283, 32'h400, lows);
    in_valid = 1'b1; in_instr = 32'h00528333; in_pc = 32'h404; flush = 1'b1;
    #1;
    chk("fl_ready", 64'(in_ready), 64'(1));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_cnt", 64'(stall_cnt), 64'(1));
    tick();
    chk("fl_dropped", 64'(out_valid), 64'(0));
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(32'h0000A283, 32'h500, lows);
      send(32'h00528333, 32'h504, lows);
    end
    send(32'h0000A283, 32'h508, lows);
    chk("pre_rst_cnt", 64'(stall_cnt), 64'(5));
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_ctrl", 64'(out_ctrl), 64'(0));
    chk("mid_rst_imm", 64'(out_imm), 64'(0));
    chk("mid_rst_pc", 64'(out_pc), 64'(0));
    chk("mid_rst_cnt", 64'(stall_cnt), 64'(0));
    for (int k = 0; k < 9; k++) begin
      send(32'h0000A283, 32'h600, lows);
      send(32'h00528333, 32'h604, lows);
    end
    chk("sat_cnt", 64'(stall_cnt), 64'(9));
    chk("sat_cnt_m", 64'(stall_cnt_m), 64'(7));
    for (int k = 0; k < 4000; k++) begin
      rst       = $urandom_range(0, 499) == 0;
      flush     = $urandom_range(0, 19) == 0;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of pc and immediate.
REQ-002 SHALL have parameter EN_M, default 0: 1 enables RV32M decode; 0 flags M opcodes illegal.
REQ-003 SHALL have parameter CNT_W, default 32: width of the stall performance counter.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  fetch offers an instruction.
REQ-007 SHALL have port in_ready  out  1  stage accepts the offered instruction this cycle.
REQ-008 SHALL have port in_instr  in  32  raw instruction.
REQ-009 SHALL have port in_pc  in  XLEN  instruction address.
REQ-010 SHALL have port flush  in  1  discard held and offered instructions (taken branch/jump).
REQ-011 SHALL have port out_valid  out  1  output register holds a decoded instruction.
REQ-012 SHALL have port out_ready  in  1  execute consumes the output this cycle.
REQ-013 SHALL have port out_ctrl  out  ctrl_t  registered decode bundle: reg_write, load, store, branch, jump, mem_to_reg[1:0], operand_a, operand_b, imm_sel[2:0], alu_control[4:0], fun3, rd, rs1, rs2, illegal.
REQ-014 SHALL have port out_imm  out  XLEN  sign-extended immediate selected by imm_sel.
REQ-015 SHALL have port out_pc  out  XLEN  pc of the held instruction.
REQ-016 SHALL have port stall_cnt  out  CNT_W  count of load-use bubbles inserted.

Function
REQ-017 SHALL decode the opcode from in_instr[6:0] (R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC); control rules match the existing single-cycle decoder.
REQ-018 SHALL encode alu_control: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 15; with EN_M=1, MUL..REMU 16..23 in funct3 order.
REQ-019 SHALL encode imm_sel: I 0, S 1, B 2, J 3, U 4; out_imm is built from the same instruction.
REQ-020 SHALL flag illegal for an unknown opcode, a bad funct7 (including funct7=0000001 when EN_M=0), or load funct3 3/6/7; an illegal instruction forces reg_write=load=store=branch=jump=0.
REQ-021 SHALL set in_ready = flush | ((!out_valid | out_ready) & !hazard).
REQ-022 SHALL load the output register on in_valid & in_ready & !flush, giving one-cycle latency from acceptance to out_valid.
REQ-023 SHALL hold out_valid and all outputs stable while out_valid & !out_ready (no change until consumed).
REQ-024 SHALL assert hazard when out_valid & out_ctrl.load & out_ctrl.rd!=0 & in_valid and the offered instruction reads out_ctrl.rd through a used rs1 or rs2 (R, I, load, store, branch, JALR use rs1; R, store, branch use rs2).
REQ-025 SHALL, on hazard with out_ready=1, clear out_valid next cycle (bubble), refuse the input, and increment stall_cnt; the held instruction is accepted the following cycle.
REQ-026 SHALL saturate stall_cnt at all-ones (no wrap).
REQ-027 SHALL, on flush, clear out_valid next cycle and drop any offered instruction; flush overrides hazard and acceptance in the same cycle.
REQ-028 SHALL give priority rst > flush > hazard > accept > hold.
REQ-029 SHALL never let rd=0 cause a hazard, and SHALL ignore x0 for reg_write consumers downstream (reg_write is passed through unchanged).

Reset
REQ-030 SHALL, while rst=1 at a rising edge, clear out_valid, out_ctrl, out_imm, out_pc and stall_cnt to 0; in_ready is 0 during reset.
REQ-031 SHALL discard any instruction in flight when reset is asserted mid-operation; no partial state survives.

Structure
REQ-032 SHALL take ctrl_t, ALU_* and IMM_* constants and opcode constants from the shared package decode_pkg.
REQ-033 SHALL contain one combinational sub-module decode_comb (instruction in, ctrl_t and imm out); decode_stage adds registers, handshake, hazard and counter logic.

Verification
REQ-034 SHALL check: 0x002081B3 (add x3,x1,x2) with out_ready=1 -> next cycle out_valid=1, alu_control=0, reg_write=1, rd=3.
REQ-035 SHALL check: 0x402081B3 -> alu_control=1; 0x022081B3 with EN_M=0 -> illegal=1, reg_write=0; with EN_M=1 -> alu_control=16.
REQ-036 SHALL check: 0x0000A283 (lw x5,0(x1)) then 0x00528333 (add x6,x5,x5) -> exactly one bubble cycle, in_ready=0 for one cycle, stall_cnt=1; with lw rd=x0 -> no bubble.
REQ-037 SHALL check: out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0, and no instruction is lost when out_ready returns to 1.
REQ-038 SHALL check: flush raised together with in_valid and a hazard -> out_valid=0 next cycle, stall_cnt unchanged, offered instruction dropped.
REQ-039 SHALL check: rst asserted while out_valid=1 and stall_cnt=5 -> all outputs 0 at the next edge.
